// File: rtl/if_stage.sv
// Instruction-fetch stage: drives a single-outstanding request bus to instruction memory
// and presents fetched words to ID, with stall buffering, delayed branch redirect and flush.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            armed_q, armed_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] buf_inst_q, buf_inst_d;
    logic            br_pend_q, br_pend_d;
    logic [XLEN-1:0] br_tgt_q, br_tgt_d;

    logic [XLEN-1:0] base_pc;
    logic [XLEN-1:0] next_pc;

    // A redirect arriving on the same edge as the delay-slot delivery is used directly.
    always_comb begin
        base_pc = (state_q == S_HOLD) ? buf_pc_q : fetch_pc_q;
        if (branch_flag_i) begin
            next_pc = branch_target_i;
        end else if (br_pend_q) begin
            next_pc = br_tgt_q;
        end else begin
            next_pc = base_pc + XLEN'(4);
        end
    end

    always_comb begin
        state_d    = state_q;
        armed_d    = 1'b1;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        br_pend_d  = br_pend_q;
        br_tgt_d   = br_tgt_q;

        if (branch_flag_i) begin
            br_pend_d = 1'b1;
            br_tgt_d  = branch_target_i;
        end

        if (flush_i) begin
            inst_d     = '0;
            valid_d    = 1'b0;
            buf_pc_d   = '0;
            buf_inst_d = '0;
            br_pend_d  = 1'b0;
            fetch_pc_d = new_pc_i;
            if (req_q && !imem_ack_i) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                addr_d  = new_pc_i;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q) begin
                        state_d = S_FETCH;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                S_FETCH: begin
                    if (!req_q) begin
                        req_d  = 1'b1;
                        addr_d = fetch_pc_q;
                    end else if (imem_ack_i) begin
                        if (!stall_i) begin
                            pc_d       = fetch_pc_q;
                            inst_d     = imem_rdata_i;
                            valid_d    = 1'b1;
                            fetch_pc_d = next_pc;
                            addr_d     = next_pc;
                            br_pend_d  = 1'b0;
                        end else begin
                            buf_pc_d   = fetch_pc_q;
                            buf_inst_d = imem_rdata_i;
                            req_d      = 1'b0;
                            state_d    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        pc_d       = buf_pc_q;
                        inst_d     = buf_inst_q;
                        valid_d    = 1'b1;
                        fetch_pc_d = next_pc;
                        addr_d     = next_pc;
                        req_d      = 1'b1;
                        br_pend_d  = 1'b0;
                        state_d    = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // Old response is dropped; restart back-to-back at the flush address.
                    if (imem_ack_i) begin
                        addr_d  = fetch_pc_q;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            fetch_pc_q <= RESET_PC;
            pc_q       <= '0;
            inst_q     <= '0;
            valid_q    <= 1'b0;
            buf_pc_q   <= '0;
            buf_inst_q <= '0;
            br_pend_q  <= 1'b0;
            br_tgt_q   <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            br_pend_q  <= br_pend_d;
            br_tgt_q   <= br_tgt_d;
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: variable-latency memory, random stall/branch/flush,
// checked every cycle against a transaction-level model of the fetch stream.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .flush_i        (flush_i),
        .new_pc_i       (new_pc_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .inst_valid_o   (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_F00D;
    endfunction

    // Inputs as sampled by the DUT at the coming edge.
    logic        r_req, r_ack, r_stall, r_br, r_fl;
    logic [31:0] r_addr, r_rdata, r_tgt, r_npc;

    // Architectural view of what ID should see and what IF should fetch next.
    logic [31:0] m_pc, m_inst, m_fetch, m_hpc, m_hinst, m_ptgt;
    logic        m_valid, m_held, m_pend, m_discard;

    task automatic deliver(input logic [31:0] a, input logic [31:0] w);
        m_pc    = a;
        m_inst  = w;
        m_valid = 1'b1;
        if (r_br)        m_fetch = r_tgt;
        else if (m_pend) m_fetch = m_ptgt;
        else             m_fetch = a + 32'd4;
        m_pend = 1'b0;
    endtask

    task automatic model_step();
        logic consumed;
        consumed = 1'b0;
        if (r_fl) begin
            m_inst    = '0;
            m_valid   = 1'b0;
            m_held    = 1'b0;
            m_pend    = 1'b0;
            m_fetch   = r_npc;
            m_discard = r_req && !r_ack;
        end else begin
            if (r_req && r_ack) begin
                if (m_discard) begin
                    m_discard = 1'b0;
                end else begin
                    check("ack_addr", r_addr, m_fetch);
                    if (!r_stall) begin
                        deliver(r_addr, r_rdata);
                        consumed = 1'b1;
                    end else begin
                        m_held  = 1'b1;
                        m_hpc   = r_addr;
                        m_hinst = r_rdata;
                    end
                end
            end else if (m_held && !r_stall) begin
                m_held = 1'b0;
                deliver(m_hpc, m_hinst);
                consumed = 1'b1;
            end
            if (r_br && !consumed) begin
                m_pend = 1'b1;
                m_ptgt = r_tgt;
            end
        end
    endtask

    int unsigned wait_cnt;
    logic        quiet;
    logic        seen;

    initial begin
        rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;
        flush_i = 1'b0; new_pc_i = '0; imem_ack_i = 1'b0; imem_rdata_i = '0;
        repeat (2) @(negedge clk);
        check("rst_req",   32'(imem_req_o), 32'd0);
        check("rst_addr",  imem_addr_o, 32'd0);
        check("rst_pc",    pc_o, 32'd0);
        check("rst_inst",  inst_o, 32'd0);
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_req", 32'(imem_req_o), 32'd0);
        @(posedge clk); #1;
        check("first_req",  32'(imem_req_o), 32'd1);
        check("first_addr", imem_addr_o, RESET_PC);

        m_pc = '0; m_inst = '0; m_valid = 1'b0; m_fetch = RESET_PC;
        m_held = 1'b0; m_hpc = '0; m_hinst = '0; m_pend = 1'b0; m_ptgt = '0; m_discard = 1'b0;
        wait_cnt = 0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            quiet = (cyc < 24) || (cyc > 400 && cyc < 416);
            stall_i         = !quiet && ($urandom_range(0, 3) == 0);
            branch_flag_i   = !quiet && ($urandom_range(0, 9) == 0);
            branch_target_i = 32'($urandom_range(0, 1023)) << 2;
            flush_i         = !quiet && ($urandom_range(0, 24) == 0);
            new_pc_i        = 32'($urandom_range(0, 1023)) << 2;
            if (cyc == 400) begin
                flush_i       = 1'b1;
                new_pc_i      = 32'hFFFF_FFF8;
                branch_flag_i = 1'b0;
            end
            if (imem_req_o && wait_cnt == 0) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = mem_word(imem_addr_o);
            end else begin
                imem_ack_i   = 1'b0;
                imem_rdata_i = 32'hDEAD_BEEF;
                if (imem_req_o) wait_cnt--;
            end
            r_req = imem_req_o; r_addr = imem_addr_o; r_ack = imem_ack_i; r_rdata = imem_rdata_i;
            r_stall = stall_i; r_br = branch_flag_i; r_tgt = branch_target_i;
            r_fl = flush_i; r_npc = new_pc_i;
            @(posedge clk); #1;
            if (r_ack) wait_cnt = quiet ? 0 : $urandom_range(0, 2);
            model_step();
            check("pc_o",  pc_o, m_pc);
            check("inst_o", inst_o, m_inst);
            check("valid", 32'(inst_valid_o), 32'(m_valid));
            if (m_held) check("hold_req", 32'(imem_req_o), 32'd0);
            if (r_req && !r_ack) begin
                check("held_req",  32'(imem_req_o), 32'd1);
                check("held_addr", imem_addr_o, r_addr);
            end
        end

        // Reset in the middle of an outstanding request.
        @(negedge clk);
        stall_i = 1'b0; branch_flag_i = 1'b0; flush_i = 1'b0; imem_ack_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = imem_req_o;
        end
        check("mid_req_seen", 32'(seen), 32'd1);
        #2;
        rst = 1'b0;
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'h1234_5678;
        #1;
        check("arst_req",   32'(imem_req_o), 32'd0);
        check("arst_addr",  imem_addr_o, 32'd0);
        check("arst_pc",    pc_o, 32'd0);
        check("arst_inst",  inst_o, 32'd0);
        check("arst_valid", 32'(inst_valid_o), 32'd0);
        @(posedge clk); #1;
        check("rst_ack_ignored", inst_o, 32'd0);
        check("rst_ack_req", 32'(imem_req_o), 32'd0);
        @(negedge clk);
        imem_ack_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("re_idle_req", 32'(imem_req_o), 32'd0);
        @(posedge clk); #1;
        check("re_first_req",  32'(imem_req_o), 32'd1);
        check("re_first_addr", imem_addr_o, RESET_PC);
        check("re_valid", 32'(inst_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
